ucca_return_monitor: RTL and testbench

- Enforcement stage directly downstream of the UCCA region-state FSM.
- Consumes `outside_ucc` plus the CPU `pc` and `irq_jmp`, and enforces control-flow integrity of the untrusted critical code (UCC) region:
  - entry only at `ucc_min`;
  - exit only from `ucc_max`;
  - resume after interrupt only at the interrupted address.
- Any violation latches a code and drives a held reset request into the MCU reset logic until execution reaches the reset handler.

---
 rtl/ucca_return_monitor_pkg.sv | 19 +
 rtl/ucca_return_monitor_reset_hold.sv | 45 ++++
 rtl/ucca_return_monitor.sv | 123 ++++++++++++
 tb/tb_ucca_return_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucca_return_monitor_pkg.sv
// rtl/ucca_return_monitor_pkg.sv - shared state encoding, violation codes and defaults
package ucca_return_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SUSP = 2'b10,
    ST_KILL = 2'b11
  } ucca_state_e;

  localparam logic [2:0] VC_NONE       = 3'd0;
  localparam logic [2:0] VC_BAD_ENTRY  = 3'd1;
  localparam logic [2:0] VC_BAD_EXIT   = 3'd2;
  localparam logic [2:0] VC_BAD_RESUME = 3'd3;
  localparam logic [2:0] VC_BAD_RANGE  = 3'd4;

  localparam logic [15:0] RESET_HANDLER_DEFAULT = 16'h0000;

endpackage

// File: rtl/ucca_return_monitor_reset_hold.sv
// rtl/ucca_return_monitor_reset_hold.sv - held reset request with minimum-duration down-counter
module ucca_reset_hold #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic system_reset,
  input  logic hold_load,
  input  logic hold_release,
  output logic reset_req,
  output logic hold_done
);

  localparam logic [15:0] LOAD_VAL = 16'(HOLD_CYCLES - 1);

  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        reset_req_q, reset_req_d;

  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    reset_req_d = reset_req_q;
    if (hold_load) begin
      hold_cnt_d  = LOAD_VAL;
      reset_req_d = 1'b1;
    end else if (hold_release) begin
      reset_req_d = 1'b0;
    end else if (reset_req_q && hold_cnt_q != 16'd0) begin
      // counts only while the request is held, saturating at zero
      hold_cnt_d = hold_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      hold_cnt_q  <= 16'd0;
      reset_req_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      reset_req_q <= reset_req_d;
    end
  end

  assign reset_req = reset_req_q;
  assign hold_done = (hold_cnt_q == 16'd0);

endmodule

// File: rtl/ucca_return_monitor.sv
// rtl/ucca_return_monitor.sv - UCC control-flow integrity enforcement: entry, exit and IRQ resume checks
module ucca_return_monitor
  import ucca_return_monitor_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEFAULT,
  parameter int          HOLD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        system_reset,
  input  logic [15:0] pc,
  input  logic [15:0] ucc_min,
  input  logic [15:0] ucc_max,
  input  logic        outside_ucc,
  input  logic        irq_jmp,
  output logic        reset_req,
  output logic [2:0]  violation_code,
  output logic [15:0] saved_pc
);

  ucca_state_e state_q, state_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] saved_pc_q, saved_pc_d;
  logic [15:0] pc_prev_q;
  logic        in_ucc;
  logic        kill;
  logic [2:0]  kill_code;
  logic        hold_release;
  logic        hold_done;

  assign in_ucc = !outside_ucc;

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    saved_pc_d   = saved_pc_q;
    kill         = 1'b0;
    kill_code    = VC_NONE;
    hold_release = 1'b0;
    if (state_q != ST_KILL && ucc_min > ucc_max) begin
      kill      = 1'b1;
      kill_code = VC_BAD_RANGE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_ucc) begin
            if (pc == ucc_min) begin
              state_d = ST_RUN;
            end else begin
              kill      = 1'b1;
              kill_code = VC_BAD_ENTRY;
            end
          end
        end
        ST_RUN: begin
          // the interrupted instruction is the one retired last cycle
          if (irq_jmp) begin
            state_d    = ST_SUSP;
            saved_pc_d = pc_prev_q;
          end else if (outside_ucc) begin
            if (pc_prev_q == ucc_max) begin
              state_d = ST_IDLE;
            end else begin
              kill      = 1'b1;
              kill_code = VC_BAD_EXIT;
            end
          end
        end
        ST_SUSP: begin
          if (in_ucc && !irq_jmp) begin
            if (pc == saved_pc_q) begin
              state_d = ST_RUN;
            end else begin
              kill      = 1'b1;
              kill_code = VC_BAD_RESUME;
            end
          end
        end
        ST_KILL: begin
          if (hold_done && pc == RESET_HANDLER) begin
            state_d      = ST_IDLE;
            hold_release = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (kill) begin
      state_d = ST_KILL;
      if (code_q == VC_NONE) begin
        code_d = kill_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q    <= ST_IDLE;
      code_q     <= VC_NONE;
      saved_pc_q <= 16'd0;
      pc_prev_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      saved_pc_q <= saved_pc_d;
      pc_prev_q  <= pc;
    end
  end

  ucca_reset_hold #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_reset_hold (
    .clk          (clk),
    .system_reset (system_reset),
    .hold_load    (kill),
    .hold_release (hold_release),
    .reset_req    (reset_req),
    .hold_done    (hold_done)
  );

  assign violation_code = code_q;
  assign saved_pc       = saved_pc_q;

endmodule

// File: tb/tb_ucca_return_monitor.sv
// tb/tb_ucca_return_monitor.sv - self-checking bench with behavioural reference model
module tb_ucca_return_monitor;

  logic        clk;
  logic        system_reset;
  logic [15:0] pc;
  logic [15:0] ucc_min;
  logic [15:0] ucc_max;
  logic        outside_ucc;
  logic        irq_jmp;
  logic        reset_req;
  logic [2:0]  violation_code;
  logic [15:0] saved_pc;

  int errors = 0;
  int checks = 0;

  // reference model: mode 0 outside, 1 inside, 2 interrupted, 3 killed
  int          m_mode;
  logic [2:0]  m_code;
  logic [15:0] m_saved;
  logic [15:0] m_prev;
  int          m_hold;
  logic        m_req;

  ucca_return_monitor dut (
    .clk            (clk),
    .system_reset   (system_reset),
    .pc             (pc),
    .ucc_min        (ucc_min),
    .ucc_max        (ucc_max),
    .outside_ucc    (outside_ucc),
    .irq_jmp        (irq_jmp),
    .reset_req      (reset_req),
    .violation_code (violation_code),
    .saved_pc       (saved_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_step(input logic rst, input logic [15:0] p, input logic irq);
    logic [15:0] last;
    logic        outside;
    int          viol;
    outside = (int'(p) < int'(ucc_min)) || (int'(p) > int'(ucc_max));
    if (rst) begin
      m_mode = 0; m_code = 0; m_saved = 0; m_prev = 0; m_hold = 0; m_req = 0;
      return;
    end
    last   = m_prev;
    m_prev = p;
    viol   = 0;
    if (m_mode == 3) begin
      if (m_hold == 0 && p == 16'h0000) begin
        m_mode = 0;
        m_req  = 0;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
      end
    end else if (int'(ucc_min) > int'(ucc_max)) begin
      viol = 4;
    end else if (m_mode == 0) begin
      if (!outside) begin
        if (p == ucc_min) m_mode = 1;
        else viol = 1;
      end
    end else if (m_mode == 1) begin
      if (irq) begin
        m_mode  = 2;
        m_saved = last;
      end else if (outside) begin
        if (last == ucc_max) m_mode = 0;
        else viol = 2;
      end
    end else begin
      if (!outside && !irq) begin
        if (p == m_saved) m_mode = 1;
        else viol = 3;
      end
    end
    if (viol != 0) begin
      m_mode = 3;
      m_req  = 1;
      m_hold = 3;
      if (m_code == 0) m_code = 3'(viol);
    end
  endtask

  // apply one cycle of inputs, advance model alongside DUT, return #1 after the edge
  task automatic drive(input logic [15:0] p, input logic irq, input logic rst);
    system_reset = rst;
    pc           = p;
    irq_jmp      = irq;
    outside_ucc  = (p < ucc_min) || (p > ucc_max);
    @(posedge clk);
    model_step(rst, p, irq);
    #1;
    system_reset = 1'b0;
  endtask

  task automatic set_range(input logic [15:0] lo, input logic [15:0] hi);
    ucc_min = lo;
    ucc_max = hi;
  endtask

  task automatic test_reset;
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    checks++;
    if (reset_req !== 1'b0 || violation_code !== 3'd0 || saved_pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset: req=%b code=%0d saved=%h, need 0 0 0000", reset_req, violation_code, saved_pc);
    end
  endtask

  task automatic test_legal_run;
    logic [15:0] seq [5];
    seq = '{16'h4000, 16'hE000, 16'hE002, 16'hE0FE, 16'h4010};
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    foreach (seq[i]) begin
      drive(seq[i], 1'b0, 1'b0);
      checks++;
      if (reset_req !== 1'b0 || violation_code !== 3'd0) begin
        errors++;
        $display("FAIL legal_run[%0d]: req=%b code=%0d, need 0 0", i, reset_req, violation_code);
      end
    end
    // re-entry after a legal exit is fine
    drive(16'hE000, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b0) begin
      errors++;
      $display("FAIL legal_reentry: req=%b, need 0", reset_req);
    end
  endtask

  task automatic test_mid_entry;
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    drive(16'h4000, 1'b0, 1'b0);
    drive(16'hE010, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b1 || violation_code !== 3'd1) begin
      errors++;
      $display("FAIL mid_entry: req=%b code=%0d, need 1 1", reset_req, violation_code);
    end
    for (int i = 0; i < 3; i++) begin
      drive(16'h0000, 1'b0, 1'b0);
      checks++;
      if (reset_req !== 1'b1) begin
        errors++;
        $display("FAIL mid_entry_hold[%0d]: req=%b, need 1", i, reset_req);
      end
    end
    drive(16'h0000, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b0 || violation_code !== 3'd1) begin
      errors++;
      $display("FAIL mid_entry_release: req=%b code=%0d, need 0 1", reset_req, violation_code);
    end
  endtask

  task automatic test_early_exit;
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    drive(16'h4000, 1'b0, 1'b0);
    drive(16'hE000, 1'b0, 1'b0);
    drive(16'hE020, 1'b0, 1'b0);
    drive(16'h4000, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b1 || violation_code !== 3'd2) begin
      errors++;
      $display("FAIL early_exit: req=%b code=%0d, need 1 2", reset_req, violation_code);
    end
  endtask

  task automatic test_irq_resume;
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    drive(16'hE000, 1'b0, 1'b0);
    drive(16'hE040, 1'b0, 1'b0);
    drive(16'hE042, 1'b1, 1'b0);
    checks++;
    if (saved_pc !== 16'hE040 || reset_req !== 1'b0) begin
      errors++;
      $display("FAIL irq_save: saved=%h req=%b, need e040 0", saved_pc, reset_req);
    end
    drive(16'h5000, 1'b0, 1'b0);
    drive(16'h5002, 1'b1, 1'b0);
    drive(16'hE040, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b0 || violation_code !== 3'd0) begin
      errors++;
      $display("FAIL irq_resume_ok: req=%b code=%0d, need 0 0", reset_req, violation_code);
    end
    drive(16'hE046, 1'b1, 1'b0);
    drive(16'h5000, 1'b0, 1'b0);
    drive(16'hE044, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b1 || violation_code !== 3'd3 || saved_pc !== 16'hE040) begin
      errors++;
      $display("FAIL irq_bad_resume: req=%b code=%0d saved=%h, need 1 3 e040", reset_req, violation_code, saved_pc);
    end
  endtask

  task automatic test_invalid_range;
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    set_range(16'hE100, 16'hE000);
    drive(16'h4000, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b1 || violation_code !== 3'd4) begin
      errors++;
      $display("FAIL bad_range: req=%b code=%0d, need 1 4", reset_req, violation_code);
    end
    set_range(16'hE000, 16'hE0FE);
    drive(16'hE010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(16'h0000, 1'b0, 1'b0);
    drive(16'hE010, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b1 || violation_code !== 3'd4) begin
      errors++;
      $display("FAIL sticky_code: req=%b code=%0d, need 1 4", reset_req, violation_code);
    end
  endtask

  task automatic test_reset_priority;
    set_range(16'hE100, 16'hE000);
    drive(16'h4000, 1'b0, 1'b1);
    checks++;
    if (reset_req !== 1'b0 || violation_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_priority: req=%b code=%0d, need 0 0", reset_req, violation_code);
    end
    set_range(16'hE000, 16'hE000);
    drive(16'hE000, 1'b0, 1'b0);
    drive(16'h4000, 1'b0, 1'b0);
    checks++;
    if (reset_req !== 1'b0 || violation_code !== 3'd0) begin
      errors++;
      $display("FAIL single_word_region: req=%b code=%0d, need 0 0", reset_req, violation_code);
    end
  endtask

  task automatic test_random;
    logic [15:0] p;
    logic        irq;
    logic        rst;
    int          r;
    set_range(16'hE000, 16'hE0FE);
    drive(16'h4000, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) set_range(16'hE100, 16'hE000);
      else if ($urandom_range(7) == 0) set_range(16'hE000, 16'hE0FE);
      r = $urandom_range(15);
      if (r < 3)       p = ucc_min;
      else if (r < 5)  p = ucc_max;
      else if (r < 7)  p = m_saved;
      else if (r < 9)  p = 16'h0000;
      else if (r < 12) p = 16'h4000 + 16'($urandom_range(255));
      else             p = 16'hE000 + 16'($urandom_range(127) * 2);
      irq = ($urandom_range(7) == 0);
      rst = ($urandom_range(99) == 0);
      drive(p, irq, rst);
      checks++;
      if (reset_req !== m_req || violation_code !== m_code || saved_pc !== m_saved) begin
        errors++;
        $display("FAIL random[%0d]: req=%b code=%0d saved=%h, need %b %0d %h",
                 n, reset_req, violation_code, saved_pc, m_req, m_code, m_saved);
      end
    end
  endtask

  initial begin
    system_reset = 1'b1;
    pc           = 16'h0000;
    ucc_min      = 16'hE000;
    ucc_max      = 16'hE0FE;
    outside_ucc  = 1'b1;
    irq_jmp      = 1'b0;
    model_step(1'b1, 16'h0000, 1'b0);
    test_reset;
    test_legal_run;
    test_mid_entry;
    test_early_exit;
    test_irq_resume;
    test_invalid_range;
    test_reset_priority;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
